en_magn_pipe: RTL and testbench
===============================

Name: en_magn_pipe

Overview:
- Streaming, parametrised DC/AC magnitude encoder for the entropy-coding path.
- Accepts one quantised coefficient per handshake.
- For DC coefficients, forms the difference against a per-component predictor.
- Emits the JPEG category (SSSS) and the left-aligned additional-bits code; sits between the zig-zag/run-length stage and the Huffman packer, with valid/ready on both sides.

Parameters:
- W, 11, coefficient width, signed two's complement. Input range is -2^(W-1)..2^(W-1)-1.
- NCH, 3, number of colour components, each with its own DC predictor.
- CW, W+1, code/difference width, derived; not overridable.
- SW, $clog2(CW+1), SSSS width, derived. Equals 4 for the defaults.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- restart  in  1  synchronous clear of all DC predictors (restart marker / new scan)
- in_valid  in  1  input coefficient valid
- in_ready  out  1  block can accept input
- in_coef  in  W  quantised coefficient, signed
- in_is_dc  in  1  1 = DC coefficient, 0 = AC coefficient
- in_ch  in  $clog2(NCH)  component index
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_ssss  out  SW  category
- out_code  out  CW  additional bits, MSB-aligned, zero-filled below
- out_is_dc  out  1  in_is_dc passed through
- out_ch  out  $clog2(NCH)  in_ch passed through

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_ssss=0, out_code=0, out_is_dc=0, out_ch=0.
  - Both pipeline stages are emptied; all predictors are cleared to 0.
  - Reset mid-stream drops in-flight items; in_ready=1 in the first cycle after reset.
- Handshake:
  - Transfer occurs on valid&&ready.
  - in_valid and the data inputs hold until accepted.
  - out_* hold stable while out_valid=1 and out_ready=0.
- Pipeline: two registered stages, S1 and S2 (S2 drives the outputs).
  - Latency: 2 cycles from the input transfer to out_valid when not stalled.
  - Throughput: 1 item per cycle.
  - S2 loads when it is empty or out_ready=1. S1 loads when it is empty or S2 loads.
  - in_ready = !s1_valid || s2_load. This is combinational; no path from in_valid to in_ready.
  - Bubbles collapse. Order is preserved. Full capacity is 2 items.
- S1 operation:
  - DC: v = sext(in_coef) - pred[in_ch], in CW bits. On transfer, pred[in_ch] <= in_coef.
  - AC: v = sext(in_coef); predictors are untouched.
- S2 operation:
  - v = 0: ssss=0, code=0.
  - Otherwise, ssss = bit-length of |v|.
  - code = low ssss bits of (v>=0 ? v : v-1), shifted left by CW-ssss.
  - |v| never exceeds 2^(CW-1)-1 for DC, so ssss <= CW-1 and no overflow case exists.
- restart:
  - All predictors are cleared to 0 at the clock edge. Items already in S1/S2 are unaffected.
  - Restart coinciding with a DC transfer: that DC uses prediction 0, then pred[in_ch] <= in_coef (the write wins over the clear).
  - Restart is honoured regardless of in_valid/in_ready.
- Out-of-range in_ch (>= NCH):
  - Treated as prediction 0, no predictor update; the item still flows through.
  - Simulation assertion flags it.
- Simultaneous S2 drain and S1 refill in one cycle is legal and required for full throughput.

Decomposition:
- Shared package en_pkg:
  - Default W/NCH constants.
  - The SSSS width function.
  - A typedef for the magnitude result struct {ssss, code}.
- One sub-module, en_magn_cat: combinational, parametrised on CW.
  - Takes v and returns ssss/code via leading-zero count and shift.
  - Instanced in S2.
- Predictor array and handshake logic stay in en_magn_pipe.

Test Plan:
- AC coefficients, W=11, out_ready=1:
  - 5 -> ssss=3, code=0xA00.
  - -5 -> ssss=3, code=0x400.
  - 0 -> ssss=0, code=0x000.
  - Each appears exactly 2 cycles after transfer.
- DC on ch0, values 10 then 7:
  - 10 -> ssss=4, code=0xA00.
  - 7 (diff -3) -> ssss=2, code=0x000.
  - Then a DC 7 on ch1 -> ssss=3, code=0xE00 (independent predictor).
- DC extremes on ch1, values -1024 then 1023:
  - -1024 -> ssss=11, code=0x7FE.
  - 1023 (diff 2047) -> ssss=11, code=0xFFE.
  - AC -1024 -> ssss=11, code=0x7FE.
- Backpressure:
  - Hold out_ready=0 and offer 3 items: 2 are accepted, then in_ready=0 and out_* stay stable.
  - Raise out_ready: all 3 emerge in order on consecutive cycles. Random valid/ready stress against a reference model shows no loss or duplication.
- Restart:
  - DC ch0 = 50, then restart with DC ch0 = 20 in the same cycle: the second item gives diff 20 -> ssss=5, code=0xA00.
  - A following DC ch0 = 20 gives diff 0 -> ssss=0.
- Reset mid-operation:
  - With 2 items stalled, pulse rst: out_valid=0 next cycle and in_ready=1.
  - A subsequent DC ch2 = 3 gives ssss=2, code=0xC00 (predictor cleared).

Source files
------------

// File: rtl/en_pkg.sv
// -----------------------------------------------------------------------------
// en_pkg
// Shared definitions for the DC/AC magnitude encoder:
//   - default coefficient width and component count
//   - ssss_width(): width of the JPEG category field for a given code width
//   - magn_res_t: {ssss, code} result at the default widths
// -----------------------------------------------------------------------------
package en_pkg;

  localparam int W_DEF   = 11;
  localparam int NCH_DEF = 3;

  // A category can take any value 0..cw, so it needs clog2(cw+1) bits.
  function automatic int ssss_width(input int cw);
    return $clog2(cw + 1);
  endfunction

  localparam int CW_DEF = W_DEF + 1;
  localparam int SW_DEF = ssss_width(CW_DEF);

  typedef struct packed {
    logic [SW_DEF-1:0] ssss;
    logic [CW_DEF-1:0] code;
  } magn_res_t;

endpackage

// File: rtl/en_magn_cat.sv
// -----------------------------------------------------------------------------
// en_magn_cat
// Combinational JPEG magnitude categoriser.
//   v_i    : signed value (two's complement, CW bits)
//   ssss_o : bit-length of |v_i| (0 when v_i is 0)
//   code_o : low ssss bits of (v>=0 ? v : v-1), MSB-aligned, zero below
// -----------------------------------------------------------------------------
module en_magn_cat
  import en_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int SW = ssss_width(CW)
) (
  input  logic [CW-1:0] v_i,
  output logic [SW-1:0] ssss_o,
  output logic [CW-1:0] code_o
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] mag_s;
  logic [CW-1:0] base_s;
  logic [SW-1:0] len_s;
  logic [SW-1:0] shamt_s;

  // Magnitude, its bit-length (highest set bit wins) and the left-aligned code.
  always_comb begin
    if (v_i[CW-1]) begin
      mag_s  = {CW{1'b0}} - v_i;
      base_s = v_i - ONE;
    end else begin
      mag_s  = v_i;
      base_s = v_i;
    end

    len_s = {SW{1'b0}};
    for (int i = 0; i < CW; i++) begin
      len_s = mag_s[i] ? SW'(i + 1) : len_s;
    end

    // Shifting by CW-ssss both aligns the code and discards the bits above
    // ssss; for v=0 the shift is CW, which clears everything.
    shamt_s = SW'(CW) - len_s;
    ssss_o  = len_s;
    code_o  = base_s << shamt_s;
  end

endmodule

// File: rtl/en_magn_pipe_chk.sv
// -----------------------------------------------------------------------------
// en_magn_pipe_chk
// Simulation checker for en_magn_pipe: flags an offered coefficient whose
// component index has no DC predictor.
//   clk, rst  : pipeline clock and synchronous reset
//   in_valid  : input valid
//   in_ch     : component index
// -----------------------------------------------------------------------------
module en_magn_pipe_chk #(
  parameter int NCH = 3,
  parameter int CHW = 2
) (
  input logic           clk,
  input logic           rst,
  input logic           in_valid,
  input logic [CHW-1:0] in_ch
);

  // Component index must address an existing predictor whenever input is offered.
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      assert (32'(in_ch) < NCH)
      else $error("en_magn_pipe: in_ch %0d has no predictor", in_ch);
    end
  end

endmodule

// File: rtl/en_magn_pipe.sv
// -----------------------------------------------------------------------------
// en_magn_pipe
// Two-stage streaming DC/AC magnitude encoder (zig-zag/RLE -> Huffman packer).
//   clk, rst            : clock, synchronous active-high reset
//   restart             : clears all DC predictors (restart marker / new scan)
//   in_valid/in_ready   : input handshake
//   in_coef/in_is_dc/in_ch : quantised coefficient, DC flag, component index
//   out_valid/out_ready : output handshake
//   out_ssss/out_code   : category and MSB-aligned additional bits
//   out_is_dc/out_ch    : pass-through of the item's DC flag and component
// S1 forms the value (DC difference against the component predictor),
// S2 holds the categorised result and drives the outputs.
// -----------------------------------------------------------------------------
module en_magn_pipe
  import en_pkg::*;
#(
  parameter  int W   = W_DEF,
  parameter  int NCH = NCH_DEF,
  localparam int CW  = W + 1,
  localparam int SW  = ssss_width(CW),
  localparam int CHW = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                restart,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_coef,
  input  logic                in_is_dc,
  input  logic [CHW-1:0]      in_ch,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SW-1:0]       out_ssss,
  output logic [CW-1:0]       out_code,
  output logic                out_is_dc,
  output logic [CHW-1:0]      out_ch
);

  logic                s2_load_s;
  logic                s1_load_s;
  logic                in_fire_s;
  logic signed [W-1:0] pred_sel_s;
  logic [CW-1:0]       v_in_s;
  logic [SW-1:0]       cat_ssss_s;
  logic [CW-1:0]       cat_code_s;

  logic                s1_valid_q, s1_valid_d;
  logic [CW-1:0]       s1_v_q,     s1_v_d;
  logic                s1_is_dc_q, s1_is_dc_d;
  logic [CHW-1:0]      s1_ch_q,    s1_ch_d;

  logic                s2_valid_q, s2_valid_d;
  logic [SW-1:0]       s2_ssss_q,  s2_ssss_d;
  logic [CW-1:0]       s2_code_q,  s2_code_d;
  logic                s2_is_dc_q, s2_is_dc_d;
  logic [CHW-1:0]      s2_ch_q,    s2_ch_d;

  logic signed [W-1:0] pred_q [NCH];
  logic signed [W-1:0] pred_d [NCH];

  // Stage-advance conditions; in_ready depends only on state and out_ready.
  always_comb begin
    s2_load_s = !s2_valid_q || out_ready;
    s1_load_s = !s1_valid_q || s2_load_s;
    in_fire_s = in_valid && s1_load_s;
  end

  // Predictor lookup; restart or an unmapped component predicts 0.
  always_comb begin
    pred_sel_s = {W{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      if (in_ch == CHW'(k)) begin
        pred_sel_s = pred_q[k];
      end else begin
        pred_sel_s = pred_sel_s;
      end
    end
    if (restart) begin
      pred_sel_s = {W{1'b0}};
    end else begin
      pred_sel_s = pred_sel_s;
    end
    if (in_is_dc) begin
      v_in_s = {in_coef[W-1], in_coef} - {pred_sel_s[W-1], pred_sel_s};
    end else begin
      v_in_s = {in_coef[W-1], in_coef};
    end
  end

  // Predictor next state: a DC write on this edge overrides a restart clear.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      if (in_fire_s && in_is_dc && (in_ch == CHW'(k))) begin
        pred_d[k] = in_coef;
      end else if (restart) begin
        pred_d[k] = {W{1'b0}};
      end else begin
        pred_d[k] = pred_q[k];
      end
    end
  end

  // S1 next state: capture the input whenever S1 may advance.
  always_comb begin
    if (s1_load_s) begin
      s1_valid_d = in_valid;
      s1_v_d     = v_in_s;
      s1_is_dc_d = in_is_dc;
      s1_ch_d    = in_ch;
    end else begin
      s1_valid_d = s1_valid_q;
      s1_v_d     = s1_v_q;
      s1_is_dc_d = s1_is_dc_q;
      s1_ch_d    = s1_ch_q;
    end
  end

  en_magn_cat #(
    .CW (CW),
    .SW (SW)
  ) u_cat (
    .v_i    (s1_v_q),
    .ssss_o (cat_ssss_s),
    .code_o (cat_code_s)
  );

  // S2 next state: take the categorised S1 content when downstream allows.
  always_comb begin
    if (s2_load_s) begin
      s2_valid_d = s1_valid_q;
      s2_ssss_d  = cat_ssss_s;
      s2_code_d  = cat_code_s;
      s2_is_dc_d = s1_is_dc_q;
      s2_ch_d    = s1_ch_q;
    end else begin
      s2_valid_d = s2_valid_q;
      s2_ssss_d  = s2_ssss_q;
      s2_code_d  = s2_code_q;
      s2_is_dc_d = s2_is_dc_q;
      s2_ch_d    = s2_ch_q;
    end
  end

  // Pipeline and predictor registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_v_q     <= {CW{1'b0}};
      s1_is_dc_q <= 1'b0;
      s1_ch_q    <= {CHW{1'b0}};
      s2_valid_q <= 1'b0;
      s2_ssss_q  <= {SW{1'b0}};
      s2_code_q  <= {CW{1'b0}};
      s2_is_dc_q <= 1'b0;
      s2_ch_q    <= {CHW{1'b0}};
      for (int k = 0; k < NCH; k++) begin
        pred_q[k] <= {W{1'b0}};
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_v_q     <= s1_v_d;
      s1_is_dc_q <= s1_is_dc_d;
      s1_ch_q    <= s1_ch_d;
      s2_valid_q <= s2_valid_d;
      s2_ssss_q  <= s2_ssss_d;
      s2_code_q  <= s2_code_d;
      s2_is_dc_q <= s2_is_dc_d;
      s2_ch_q    <= s2_ch_d;
      for (int k = 0; k < NCH; k++) begin
        pred_q[k] <= pred_d[k];
      end
    end
  end

  assign in_ready  = s1_load_s;
  assign out_valid = s2_valid_q;
  assign out_ssss  = s2_ssss_q;
  assign out_code  = s2_code_q;
  assign out_is_dc = s2_is_dc_q;
  assign out_ch    = s2_ch_q;

  en_magn_pipe_chk #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ch    (in_ch)
  );

endmodule

// File: tb/tb_en_magn_pipe.sv
// -----------------------------------------------------------------------------
// tb_en_magn_pipe
// Directed and randomised bench for en_magn_pipe. Expected results come from a
// queue-based model that encodes values with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_en_magn_pipe;
  import en_pkg::*;

  localparam int W   = 11;
  localparam int NCH = 3;
  localparam int CW  = 12;
  localparam int SW  = 4;
  localparam int CHW = 2;

  logic                clk = 1'b0;
  logic                rst, restart, in_valid, in_ready, in_is_dc;
  logic                out_valid, out_ready, out_is_dc;
  logic signed [W-1:0] in_coef;
  logic [CHW-1:0]      in_ch, out_ch;
  logic [SW-1:0]       out_ssss;
  logic [CW-1:0]       out_code;

  always #5 clk = ~clk;

  en_magn_pipe #(.W(W), .NCH(NCH)) dut (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .in_is_dc  (in_is_dc),
    .in_ch     (in_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ssss  (out_ssss),
    .out_code  (out_code),
    .out_is_dc (out_is_dc),
    .out_ch    (out_ch)
  );

  typedef struct {
    magn_res_t r;
    bit        dc;
    int        ch;
  } exp_t;

  exp_t           q[$];
  int             pred[NCH];
  int             n_cmp = 0;
  int             n_err = 0;
  int             n_acc = 0;
  int             n_emit = 0;
  bit             last_fire = 1'b0;
  bit             prev_stall = 1'b0;
  logic [SW-1:0]  prev_ssss;
  logic [CW-1:0]  prev_code;
  logic           prev_dc;
  logic [CHW-1:0] prev_ch;

  // JPEG category/code from the arithmetic definition.
  function automatic magn_res_t model_enc(input int v);
    magn_res_t r;
    int m, n, c, code;
    m = (v < 0) ? -v : v;
    n = 0;
    while (m > 0) begin
      m = m / 2;
      n++;
    end
    c = (v < 0) ? (v + (1 << n) - 1) : v;
    code = c * (1 << (CW - n));
    r.ssss = n[SW-1:0];
    r.code = code[CW-1:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, update the model at the rising edge.
  task automatic cycle();
    bit   i_fire, o_fire, s_rst, s_rest, s_dc;
    int   s_coef, s_ch, p;
    exp_t e;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || (out_ready == 1'b1)));
    if (out_valid === 1'b1) begin
      chk("out_has_item", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        chk("sb_ssss", 32'(out_ssss), 32'(q[0].r.ssss));
        chk("sb_code", 32'(out_code), 32'(q[0].r.code));
        chk("sb_is_dc", 32'(out_is_dc), 32'(q[0].dc));
        chk("sb_ch", 32'(out_ch), q[0].ch);
      end
    end
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_ssss", 32'(out_ssss), 32'(prev_ssss));
      chk("stall_code", 32'(out_code), 32'(prev_code));
      chk("stall_dc", 32'(out_is_dc), 32'(prev_dc));
      chk("stall_ch", 32'(out_ch), 32'(prev_ch));
    end
    i_fire = in_valid && in_ready;
    o_fire = out_valid && out_ready;
    s_rst  = rst;
    s_rest = restart;
    s_dc   = in_is_dc;
    s_coef = int'(in_coef);
    s_ch   = int'(in_ch);
    prev_stall = out_valid && !out_ready;
    prev_ssss  = out_ssss;
    prev_code  = out_code;
    prev_dc    = out_is_dc;
    prev_ch    = out_ch;
    @(posedge clk);
    if (s_rst) begin
      n_acc = n_acc - q.size();
      q.delete();
      foreach (pred[k]) pred[k] = 0;
      prev_stall = 1'b0;
      i_fire = 1'b0;
    end else begin
      if (o_fire) begin
        if (q.size() > 0) void'(q.pop_front());
        n_emit++;
      end
      if (i_fire) begin
        p = (s_rest || s_ch >= NCH) ? 0 : pred[s_ch];
        e.r  = model_enc(s_dc ? (s_coef - p) : s_coef);
        e.dc = s_dc;
        e.ch = s_ch;
        q.push_back(e);
        n_acc++;
      end
      if (s_rest) foreach (pred[k]) pred[k] = 0;
      if (i_fire && s_dc && s_ch < NCH) pred[s_ch] = s_coef;
    end
    last_fire = i_fire;
    #1;
  endtask

  // Send one item into an empty pipeline with out_ready=1 and check exact latency.
  task automatic single(input string tag, input bit dc, input int ch, input int coef,
                        input bit rs, input int e_ssss, input int e_code);
    in_valid = 1'b1;
    in_is_dc = dc;
    in_ch    = ch[CHW-1:0];
    in_coef  = coef[W-1:0];
    restart  = rs;
    cycle();
    chk({tag, "_acc"}, 32'(last_fire), 32'd1);
    in_valid = 1'b0;
    restart  = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    cycle();
    chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
    chk({tag, "_ssss"}, 32'(out_ssss), 32'(e_ssss));
    chk({tag, "_code"}, 32'(out_code), 32'(e_code));
    cycle();
  endtask

  initial begin
    rst = 1'b1; restart = 1'b0; in_valid = 1'b0; in_is_dc = 1'b0;
    in_ch = '0; in_coef = '0; out_ready = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ssss", 32'(out_ssss), 32'd0);
    chk("rst_code", 32'(out_code), 32'd0);
    chk("rst_dc", 32'(out_is_dc), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // AC categories.
    single("ac_p5", 1'b0, 0, 5, 1'b0, 3, 'hA00);
    single("ac_m5", 1'b0, 0, -5, 1'b0, 3, 'h400);
    single("ac_0", 1'b0, 0, 0, 1'b0, 0, 'h000);
    // DC differences and independent predictors.
    single("dc0_10", 1'b1, 0, 10, 1'b0, 4, 'hA00);
    single("dc0_7", 1'b1, 0, 7, 1'b0, 2, 'h000);
    single("dc1_7", 1'b1, 1, 7, 1'b0, 3, 'hE00);
    // Restart on its own clears predictors before the extremes.
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    single("dc1_min", 1'b1, 1, -1024, 1'b0, 11, 'h7FE);
    single("dc1_max", 1'b1, 1, 1023, 1'b0, 11, 'hFFE);
    single("ac_min", 1'b0, 0, -1024, 1'b0, 11, 'h7FE);
    // Restart coinciding with a DC transfer.
    single("rs_50", 1'b1, 0, 50, 1'b0, 6, 'hC80);
    single("rs_20", 1'b1, 0, 20, 1'b1, 5, 'hA00);
    single("rs_20b", 1'b1, 0, 20, 1'b0, 0, 'h000);

    // Backpressure: capacity 2, then ordered drain on consecutive cycles.
    out_ready = 1'b0; in_valid = 1'b1; in_is_dc = 1'b0; in_ch = 2'd0;
    in_coef = 11'sd1;
    cycle();
    chk("bp_acc1", 32'(last_fire), 32'd1);
    in_coef = 11'sd2;
    cycle();
    chk("bp_acc2", 32'(last_fire), 32'd1);
    in_coef = 11'sd3;
    cycle();
    chk("bp_rej3", 32'(last_fire), 32'd0);
    chk("bp_full", 32'(in_ready), 32'd0);
    cycle();
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_ssss", 32'(out_ssss), 32'd1);
    chk("bp_hold_code", 32'(out_code), 32'h800);
    out_ready = 1'b1;
    cycle();
    chk("bp_acc3", 32'(last_fire), 32'd1);
    in_valid = 1'b0;
    chk("bp_out2_valid", 32'(out_valid), 32'd1);
    chk("bp_out2_ssss", 32'(out_ssss), 32'd2);
    chk("bp_out2_code", 32'(out_code), 32'h800);
    cycle();
    chk("bp_out3_valid", 32'(out_valid), 32'd1);
    chk("bp_out3_ssss", 32'(out_ssss), 32'd2);
    chk("bp_out3_code", 32'(out_code), 32'hC00);
    cycle();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Reset while two items are stalled.
    out_ready = 1'b0; in_valid = 1'b1; in_is_dc = 1'b1; in_ch = 2'd2;
    in_coef = 11'sd100;
    cycle();
    in_coef = -11'sd7;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("mr_stalled", 32'(out_valid), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    single("mr_dc2_3", 1'b1, 2, 3, 1'b0, 2, 'hC00);

    // Random valid/ready/restart stress against the model.
    for (int i = 0; i < 800; i++) begin
      if (!in_valid || last_fire) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_coef  = W'($urandom);
        in_is_dc = ($urandom_range(0, 1) == 1);
        in_ch    = CHW'($urandom_range(0, NCH - 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      restart   = ($urandom_range(0, 15) == 0);
      cycle();
    end
    in_valid = 1'b0; restart = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("drain_count", n_emit, n_acc);
    chk("drain_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
